// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n: N-floor elevator controller with a tick prescaler,
// latched floor calls, SCAN scheduling, a timed door and a move counter.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             prescaler enable (0 holds the count, no ticks)
//   stop           emergency hold: FSM, floor and door timer frozen
//   req            per-floor call buttons (level or pulse)
//   tick           one-cycle pulse every TICK_DIV enabled cycles
//   floor          current floor index
//   dir_up         current/last scan direction (1 = up)
//   moving         travelling up or down
//   door_open      door phase at the current floor
//   pending        latched outstanding calls
//   changes_count  floors traversed, wraps modulo 2^CNT_W
module elevator_ctrl_n #(
    parameter int N_FLOORS   = 8,
    parameter int FLOOR_W    = 3,
    parameter int TICK_DIV   = 50000000,
    parameter int DOOR_TICKS = 3,
    parameter int CNT_W      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                stop,
    input  logic [N_FLOORS-1:0] req,
    output logic                tick,
    output logic [FLOOR_W-1:0]  floor,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending,
    output logic [CNT_W-1:0]    changes_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = $clog2(DOOR_TICKS + 1);
    localparam int NP = 1 << FLOOR_W;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR
    } state_t;

    state_t             state, state_nx;
    logic [PW-1:0]      pre_cnt;
    logic [FLOOR_W-1:0] floor_nx;
    logic               dir_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic [CNT_W-1:0]   cnt_nx;
    logic [NP-1:0]      pend_x, req_x, clear;
    logic               above, below, adv;

    // ---------------- prescaler ----------------
    assign tick = en && (pre_cnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
        end
    end

    assign adv = tick && !stop;

    // Widen to the full floor-index range so any floor value indexes safely.
    always_comb begin
        pend_x = '0;
        req_x  = '0;
        pend_x[N_FLOORS-1:0] = pending;
        req_x[N_FLOORS-1:0]  = req;
    end

    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > floor)) above = 1'b1;
            if (pending[i] && (FLOOR_W'(i) < floor)) below = 1'b1;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nx = state;
        floor_nx = floor;
        dir_nx   = dir_up;
        timer_nx = timer;
        cnt_nx   = changes_count;
        unique case (state)
            IDLE: begin
                if (adv) begin
                    if (pend_x[floor]) begin
                        state_nx = DOOR;
                        timer_nx = TW'(DOOR_TICKS);
                    end else if (dir_up && above) begin
                        state_nx = MOVE_UP;
                    end else if (below) begin
                        state_nx = MOVE_DOWN;
                        dir_nx   = 1'b0;
                    end else if (above) begin
                        state_nx = MOVE_UP;
                        dir_nx   = 1'b1;
                    end
                end
            end
            MOVE_UP: begin
                if (adv) begin
                    floor_nx = floor + FLOOR_W'(1);
                    cnt_nx   = changes_count + CNT_W'(1);
                    if (pend_x[floor_nx]) begin
                        state_nx = DOOR;
                        timer_nx = TW'(DOOR_TICKS);
                    end
                end
            end
            MOVE_DOWN: begin
                if (adv) begin
                    floor_nx = floor - FLOOR_W'(1);
                    cnt_nx   = changes_count + CNT_W'(1);
                    if (pend_x[floor_nx]) begin
                        state_nx = DOOR;
                        timer_nx = TW'(DOOR_TICKS);
                    end
                end
            end
            DOOR: begin
                // A fresh call at this floor keeps the door open.
                if (!stop && req_x[floor]) begin
                    timer_nx = TW'(DOOR_TICKS);
                end else if (adv) begin
                    if (timer == TW'(1)) begin
                        if (dir_up && above) begin
                            state_nx = MOVE_UP;
                        end else if (below) begin
                            state_nx = MOVE_DOWN;
                            dir_nx   = 1'b0;
                        end else if (above) begin
                            state_nx = MOVE_UP;
                            dir_nx   = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        timer_nx = timer - TW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // Served floor: the one we are in DOOR at, or are entering DOOR at.
    always_comb begin
        clear = '0;
        if (state == DOOR) begin
            clear[floor] = 1'b1;
        end else if (state_nx == DOOR) begin
            clear[floor_nx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            floor         <= '0;
            dir_up        <= 1'b1;
            timer         <= '0;
            changes_count <= '0;
            pending       <= '0;
        end else begin
            state         <= state_nx;
            floor         <= floor_nx;
            dir_up        <= dir_nx;
            timer         <= timer_nx;
            changes_count <= cnt_nx;
            pending       <= (pending | req) & ~clear[N_FLOORS-1:0];
        end
    end

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR);

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n: directed and random stimulus for elevator_ctrl_n,
// checked against a floor/direction reference model.
module tb_elevator_ctrl_n;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TD = 4;
    localparam int DT = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst, en, stop;
    logic [NF-1:0] req;
    logic          tick, dir_up, moving, door_open;
    logic [FW-1:0] floor;
    logic [NF-1:0] pending;
    logic [CW-1:0] changes_count;

    always #5 clk = ~clk;

    elevator_ctrl_n #(
        .N_FLOORS(NF), .FLOOR_W(FW), .TICK_DIV(TD),
        .DOOR_TICKS(DT), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .stop(stop), .req(req),
        .tick(tick), .floor(floor), .dir_up(dir_up), .moving(moving),
        .door_open(door_open), .pending(pending),
        .changes_count(changes_count)
    );

    int errors = 0;
    int checks = 0;

    // reference model: travel is +1/-1/0, door is a separate flag
    int          m_cnt, m_floor, m_travel, m_timer, m_moves;
    bit          m_dir, m_door;
    bit [NF-1:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_floor = 0; m_travel = 0; m_timer = 0;
        m_moves = 0; m_dir = 1; m_door = 0; m_pend = '0;
    endtask

    function automatic bit calls_above();
        for (int i = m_floor + 1; i < NF; i++)
            if (m_pend[i]) return 1;
        return 0;
    endfunction

    function automatic bit calls_below();
        for (int i = 0; i < m_floor; i++)
            if (m_pend[i]) return 1;
        return 0;
    endfunction

    task automatic pick_direction();
        bit up, dn;
        up = calls_above();
        dn = calls_below();
        if (m_dir && up) m_travel = 1;
        else if (dn) begin m_travel = -1; m_dir = 0; end
        else if (up) begin m_travel = 1; m_dir = 1; end
        else m_travel = 0;
    endtask

    task automatic model_edge();
        bit          tk, adv;
        bit [NF-1:0] clr;
        tk  = en && (m_cnt == TD - 1);
        adv = tk && !stop;
        clr = '0;
        if (m_door) begin
            clr[m_floor] = 1;
            if (!stop && req[m_floor]) m_timer = DT;
            else if (adv) begin
                if (m_timer == 1) begin
                    m_door = 0;
                    pick_direction();
                end else m_timer--;
            end
        end else if (adv) begin
            if (m_travel == 0) begin
                if (m_pend[m_floor]) begin
                    m_door = 1; m_timer = DT; clr[m_floor] = 1;
                end else pick_direction();
            end else begin
                m_floor += m_travel;
                m_moves++;
                if (m_pend[m_floor]) begin
                    m_travel = 0; m_door = 1; m_timer = DT;
                    clr[m_floor] = 1;
                end
            end
        end
        m_pend = (m_pend | req) & ~clr;
        if (en) m_cnt = tk ? 0 : m_cnt + 1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".tick"}, tick, (en && m_cnt == TD - 1));
        chk({tag, ".floor"}, floor, m_floor);
        chk({tag, ".dir_up"}, dir_up, m_dir);
        chk({tag, ".moving"}, moving, (m_travel != 0));
        chk({tag, ".door"}, door_open, m_door);
        chk({tag, ".pending"}, pending, m_pend);
        chk({tag, ".count"}, changes_count, m_moves % (1 << CW));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all("cyc");
    endtask

    initial begin
        int   n, k;
        int   stops[$];
        logic prev;

        rst = 1; en = 0; stop = 0; req = '0;
        model_reset();
        #2;
        check_all("reset");
        #10;
        rst = 0;

        // tick generation
        en = 1; n = 0;
        for (int i = 0; i < 12; i++) begin
            if (tick) n++;
            step();
        end
        chk("ticks_in_12", n, 3);
        for (int i = 0; i < 5; i++) step();
        en = 0; n = 0;
        for (int i = 0; i < 10; i++) begin
            if (tick) n++;
            step();
        end
        chk("ticks_held", n, 0);
        en = 1; k = 1;
        while (!tick && k < 20) begin step(); k++; end
        chk("tick_resume", k, 3);

        // single request to floor 5
        req = 8'h20; step(); req = '0;
        for (int i = 0; i < 100 && !door_open; i++) step();
        chk("single.floor", floor, 5);
        chk("single.pend5", pending[5], 0);
        for (int i = 0; i < 100 && (door_open || moving); i++) step();
        chk("single.count", changes_count, 1);

        // park at floor 2
        req = 8'h04; step(); req = '0;
        for (int i = 0; i < 100 && !door_open; i++) step();
        for (int i = 0; i < 100 && (door_open || moving); i++) step();
        chk("park.floor", floor, 2);

        // SCAN order
        req = 8'h10; step(); req = '0;
        for (int i = 0; i < 20 && !moving; i++) step();
        chk("scan.start", floor, 2);
        req = 8'h42; step(); req = '0;
        prev = door_open;
        for (int i = 0; i < 400 && stops.size() < 3; i++) begin
            step();
            if (door_open && !prev) stops.push_back(int'(floor));
            prev = door_open;
        end
        chk("scan.stop0", stops.size() > 0 ? stops[0] : -1, 4);
        chk("scan.stop1", stops.size() > 1 ? stops[1] : -1, 6);
        chk("scan.stop2", stops.size() > 2 ? stops[2] : -1, 1);
        chk("scan.count", changes_count, 1);
        for (int i = 0; i < 100 && (door_open || moving); i++) step();

        // emergency stop between floors 3 and 4
        req = 8'h40; step(); req = '0;
        for (int i = 0; i < 100 && !(moving && floor == 3); i++) step();
        stop = 1;
        for (int i = 0; i < 20; i++) step();
        chk("stop.floor", floor, 3);
        chk("stop.moving", moving, 1);
        chk("stop.pending", pending, 8'h40);
        stop = 0;
        for (int i = 0; i < 10 && !tick; i++) step();
        step();
        chk("stop.resume", floor, 4);

        // door extend at floor 6
        for (int i = 0; i < 100 && !door_open; i++) step();
        chk("door.floor", floor, 6);
        req = 8'h40; step(); req = '0;
        chk("door.pend6", pending[6], 0);
        n = 0;
        for (int i = 0; i < 100 && door_open; i++) begin
            if (tick) n++;
            step();
        end
        chk("door.extend", n, 2);

        // reset mid-move at floor 3
        req = 8'h01; step(); req = '0;
        for (int i = 0; i < 100 && !(moving && floor == 3); i++) step();
        chk("pre_rst.moving", moving, 1);
        req = 8'h80;
        rst = 1;
        #1;
        chk("rst.floor", floor, 0);
        chk("rst.pending", pending, 0);
        chk("rst.count", changes_count, 0);
        chk("rst.door", door_open, 0);
        chk("rst.dir", dir_up, 1);
        chk("rst.moving", moving, 0);
        model_reset();
        @(posedge clk);
        #1;
        req = '0; rst = 0;
        check_all("rst_hold");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            stop = ($urandom_range(0, 24) == 0);
            req  = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
